estagio_decodificacao: RTL

- Pipelined, parametrised MIPS decode stage between instruction fetch and register read.
- Accepts {instrucao, pc} through a valid/ready handshake and classifies each word as R, I, J or illegal.
- Zeroes fields outside the instruction's format, extends the immediate and computes branch/jump targets.
- Buffers decoded results in a DEPTH-entry FIFO with a flush input, and keeps saturating statistics counters.

---
 rtl/estagio_decodificacao.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/estagio_decodificacao.sv
// MIPS decode stage: classifies each fetched word, extends the immediate, computes
// branch/jump targets and queues the decoded result in a small FIFO with statistics.
module estagio_decodificacao #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instrucao,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm_ext,
    output logic [PC_W-1:0]  alvo,
    output logic [1:0]       tipo,
    output logic [CNT_W-1:0] cnt_dec,
    output logic [CNT_W-1:0] cnt_ilegal
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [1:0] {
        TIPO_R      = 2'b00,
        TIPO_I      = 2'b01,
        TIPO_J      = 2'b10,
        TIPO_ILEGAL = 2'b11
    } tipo_e;

    typedef struct packed {
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [IMM_W-1:0] imm;
        logic [PC_W-1:0]  alvo;
        tipo_e            tipo;
    } entry_t;

    logic [PC_W-1:0]  w_pc4;
    logic [PC_W-1:0]  w_br_off;
    logic [31:0]      w_jt;
    logic [IMM_W-1:0] w_imm_s;
    logic [IMM_W-1:0] w_imm_z;
    entry_t           w_dec;
    entry_t           w_head;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_cnt_dec;
    logic [CNT_W-1:0] r_cnt_ilegal;

    // Jump target keeps the top nibble of pc+4 (zero when PC_W is 28).
    assign w_pc4    = in_pc + PC_W'(4);
    assign w_br_off = PC_W'($signed({instrucao[15:0], 2'b00}));
    assign w_jt     = (32'(w_pc4) & 32'hF000_0000) | {4'b0000, instrucao[25:0], 2'b00};
    assign w_imm_s  = IMM_W'($signed(instrucao[15:0]));
    assign w_imm_z  = IMM_W'(instrucao[15:0]);

    always_comb begin
        w_dec        = '0;
        w_dec.opcode = instrucao[31:26];
        case (instrucao[31:26])
            OP_R: begin
                w_dec.tipo  = TIPO_R;
                w_dec.rs    = instrucao[25:21];
                w_dec.rt    = instrucao[20:16];
                w_dec.rd    = instrucao[15:11];
                w_dec.shamt = instrucao[10:6];
                w_dec.funct = instrucao[5:0];
            end
            OP_J, OP_JAL: begin
                w_dec.tipo = TIPO_J;
                w_dec.alvo = w_jt[PC_W-1:0];
            end
            OP_BEQ, OP_BNE: begin
                w_dec.tipo = TIPO_I;
                w_dec.rs   = instrucao[25:21];
                w_dec.rt   = instrucao[20:16];
                w_dec.imm  = w_imm_s;
                w_dec.alvo = w_pc4 + w_br_off;
            end
            OP_ANDI, OP_ORI: begin
                w_dec.tipo = TIPO_I;
                w_dec.rs   = instrucao[25:21];
                w_dec.rt   = instrucao[20:16];
                w_dec.imm  = w_imm_z;
            end
            OP_LW, OP_SW, OP_ADDI, OP_SLTI: begin
                w_dec.tipo = TIPO_I;
                w_dec.rs   = instrucao[25:21];
                w_dec.rt   = instrucao[20:16];
                w_dec.imm  = w_imm_s;
            end
            default: w_dec.tipo = TIPO_ILEGAL;
        endcase
    end

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign in_ready  = !w_full;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Pops during a flush cycle still count; flush never clears statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_dec    <= '0;
            r_cnt_ilegal <= '0;
        end else if (w_pop) begin
            if (r_cnt_dec != '1) r_cnt_dec <= r_cnt_dec + 1'b1;
            if (w_head.tipo == TIPO_ILEGAL && r_cnt_ilegal != '1)
                r_cnt_ilegal <= r_cnt_ilegal + 1'b1;
        end
    end

    // Stale memory contents are hidden whenever the FIFO is empty.
    assign w_head     = out_valid ? r_mem[r_rd_ptr] : '0;
    assign opcode     = w_head.opcode;
    assign rs         = w_head.rs;
    assign rt         = w_head.rt;
    assign rd         = w_head.rd;
    assign shamt      = w_head.shamt;
    assign funct      = w_head.funct;
    assign imm_ext    = w_head.imm;
    assign alvo       = w_head.alvo;
    assign tipo       = w_head.tipo;
    assign cnt_dec    = r_cnt_dec;
    assign cnt_ilegal = r_cnt_ilegal;

endmodule
